accum_alu_seq: RTL
==================

Name: accum_alu_seq

Overview:
Parametrised accumulator/ALU for the bus-based datapath. It is the next generation of the fixed 8-bit add/sub accumulator: configurable width, a 4-bit opcode with arithmetic, logic, shift and a multi-cycle multiply, four registered flags, and a valid/ready command handshake. The accumulator value is presented to the shared bus through an explicit output-enable rather than an internal tri-state.

Parameters:
WIDTH, 8, datapath, accumulator and operand width in bits (>= 2).
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as NOP.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  command valid.
in_ready  output  1  block can accept a command; equals !busy.
op  input  4  opcode, sampled on accept.
operand  input  WIDTH  B operand, sampled on accept.
acc_oe  input  1  bus output enable.
bus_out  output  WIDTH  acc when acc_oe=1, else 0 (combinational).
acc  output  WIDTH  accumulator register.
cf, zf, nf, vf  output  1 each  carry, zero, negative, overflow flags (registered).
busy  output  1  multi-cycle op in progress.
done  output  1  one-cycle pulse when a result is written.

Behaviour:
- Reset (async, active-high): acc=0, cf=zf=nf=vf=0, busy=0, done=0, in_ready=1. Assertion during a MUL aborts it. The multiplier state is cleared.
- Accept condition: in_valid && in_ready at a rising edge.
- Opcodes: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 ADC, 5 SBB, 6 AND, 7 OR, 8 XOR, 9 SHL, 10 SHR, 11 MUL, 12 CLRF. Codes 13-15 are NOP.
- Single-cycle ops: acc and flags update on the accept edge. done=1 in the following cycle. in_ready stays 1, so back-to-back issue is allowed every cycle.
- NOP: no acc/flag change; done still pulses.
- Arithmetic: computed in WIDTH+1 bits.
  - ADD: acc+operand.
  - ADC: acc+operand+cf.
  - SUB: acc+~operand+1.
  - SBB: acc+~operand+cf.
  - cf = bit WIDTH of the sum. For SUB/SBB, cf=1 means no borrow.
  - vf = signed overflow (operand sign equal, result sign differs; use ~operand for SUB/SBB).
  - zf = (result==0). nf = result MSB.
- LOAD, AND, OR, XOR: zf and nf updated, vf cleared, cf held.
- SHL: cf=acc MSB, acc=acc<<1. SHR (logical): cf=acc LSB, acc=acc>>1. Both update zf and nf and clear vf.
- CLRF: all flags cleared; acc held.
- MUL (shift-add, unsigned):
  - On accept: busy=1, in_ready=0. Multiplicand=acc, multiplier=operand, 2*WIDTH product register=0.
  - Runs WIDTH iterations, one per cycle. After the WIDTH-th iteration edge, acc=low WIDTH bits of the product and busy=0.
  - done=1 in the cycle after that final edge, so total latency from accept to done is WIDTH+1 cycles (8-bit: 9 cycles).
  - cf=vf=(high half != 0). zf and nf taken from the low half.
  - in_valid is ignored while busy; the command is not lost, because the source holds it until in_ready.
- acc_oe acts only on bus_out and may change in any cycle, including while busy. bus_out shows acc's pre-MUL value until the final write.
- Wrap-around: all results are modulo 2^WIDTH. No saturation.
- MUL_EN=0: opcode 11 behaves as NOP; busy never asserts.

Decomposition:
- Package accum_pkg:
  - op_e enum (4-bit opcode values above).
  - flags_t struct {cf, zf, nf, vf}.
  - OP_W=4 constant.
  - Function for signed-overflow detection.
- Sub-module accum_mul_seq (WIDTH parameter):
  - Shift-add engine with start/busy/done.
  - Outputs a 2*WIDTH product.
  - Instantiated under a generate on MUL_EN.
- Top-level contents: opcode decode, the single-cycle ALU, the flag register and the handshake.

Test Plan:
- Reset then LOAD 0x7F, ADD 0x01 (WIDTH=8) -> acc=0x80, cf=0, vf=1, nf=1, zf=0; done pulses once per op.
- LOAD 0xFF, ADD 0x01, then ADC 0x00 -> acc=0x00, cf=1, zf=1; then acc=0x01, cf=0, zf=0.
- LOAD 0x05, SUB 0x06 -> acc=0xFF, cf=0 (borrow), nf=1; SBB 0x00 -> acc=0xFE, cf=1.
- LOAD 0x0C, MUL 0x0B with in_valid held high -> busy for 8 cycles and in_ready=0; done 9 cycles after accept; acc=0x84, cf=0. Then LOAD 0x20, MUL 0x10 -> acc=0x00, cf=vf=1, zf=1.
- Assert rst mid-MUL at iteration 3 -> acc=0, flags=0, busy=0, in_ready=1 immediately (asynchronous); no done pulse.
- acc=0xA5, toggle acc_oe every cycle -> bus_out alternates 0xA5/0x00; SHL -> acc=0x4A, cf=1; SHR -> acc=0x25, cf=0.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types for the accumulator/ALU: opcodes, flag bundle,
// and the signed-overflow helper used by the add/sub path.
package accum_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_ADC  = 4'd4,
    OP_SBB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_MUL  = 4'd11,
    OP_CLRF = 4'd12
  } op_e;

  typedef struct packed {
    logic cf;
    logic zf;
    logic nf;
    logic vf;
  } flags_t;

  // Inputs are the sign bits of both addends and of the result.
  function automatic logic add_ovf(
    input logic a,
    input logic b,
    input logic r
  );
    return (a == b) && (r != a);
  endfunction

endpackage

// File: rtl/accum_mul_seq.sv
// Unsigned shift-add multiplier, one iteration per clock.
// Ports: clk, rst (async high), start, mcand, mplier in;
//        busy, last, done, product (running value incl. this cycle) out.
module accum_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               last,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   mc_q;
  logic [WIDTH-1:0]     mp_q;

  // product already includes the partial sum of the current cycle,
  // so the owner can capture the final value on the last edge.
  assign product = prod_q + (mp_q[0] ? mc_q : '0);
  assign last    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      prod_q <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy   <= 1'b1;
        cnt    <= '0;
        prod_q <= '0;
        mc_q   <= {{WIDTH{1'b0}}, mcand};
        mp_q   <= mplier;
      end else if (busy) begin
        prod_q <= product;
        mc_q   <= mc_q << 1;
        mp_q   <= mp_q >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/accum_alu_seq.sv
// Parametrised accumulator/ALU with registered flags and valid/ready issue.
// Ports: clk, rst, in_valid, op, operand, acc_oe in; in_ready, bus_out, acc,
//        cf/zf/nf/vf, busy, done out. bus_out is acc gated by acc_oe.
module accum_alu_seq #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             acc_oe,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] acc,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf,
  output logic             busy,
  output logic             done
);

  import accum_pkg::*;

  flags_t             fl_q;
  flags_t             fl_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   arith_b;
  logic               arith_ci;
  logic               accept;
  logic               mul_start;
  logic               done_q;

  logic               mul_busy;
  logic               mul_last;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   mul_hi;

  assign busy      = mul_busy;
  assign in_ready  = !mul_busy;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && MUL_EN && (op == OP_MUL);
  assign done      = done_q | mul_done;
  assign bus_out   = acc_oe ? acc : '0;

  assign cf = fl_q.cf;
  assign zf = fl_q.zf;
  assign nf = fl_q.nf;
  assign vf = fl_q.vf;

  assign mul_lo = mul_prod[WIDTH-1:0];
  assign mul_hi = mul_prod[2*WIDTH-1:WIDTH];

  generate
    if (MUL_EN) begin : g_mul
      accum_mul_seq #(
        .WIDTH (WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   (acc),
        .mplier  (operand),
        .busy    (mul_busy),
        .last    (mul_last),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_busy = 1'b0;
      assign mul_last = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  // Shared WIDTH+1 adder: subtraction is acc + ~b + carry-in.
  always_comb begin
    arith_b  = operand;
    arith_ci = 1'b0;
    unique case (op)
      OP_ADC:  arith_ci = fl_q.cf;
      OP_SUB:  begin
        arith_b  = ~operand;
        arith_ci = 1'b1;
      end
      OP_SBB:  begin
        arith_b  = ~operand;
        arith_ci = fl_q.cf;
      end
      default: ;
    endcase
    sum = {1'b0, acc} + {1'b0, arith_b}
        + {{WIDTH{1'b0}}, arith_ci};
  end

  always_comb begin
    acc_d = acc;
    fl_d  = fl_q;
    unique case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        acc_d = sum[WIDTH-1:0];
        fl_d.cf = sum[WIDTH];
        fl_d.vf = add_ovf(acc[WIDTH-1],
                          arith_b[WIDTH-1],
                          sum[WIDTH-1]);
      end
      OP_LOAD: acc_d = operand;
      OP_AND:  acc_d = acc & operand;
      OP_OR:   acc_d = acc | operand;
      OP_XOR:  acc_d = acc ^ operand;
      OP_SHL:  begin
        acc_d   = acc << 1;
        fl_d.cf = acc[WIDTH-1];
      end
      OP_SHR:  begin
        acc_d   = acc >> 1;
        fl_d.cf = acc[0];
      end
      OP_CLRF: fl_d = '0;
      default: ;
    endcase
    unique case (op)
      OP_LOAD, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR: fl_d.vf = 1'b0;
      default: ;
    endcase
    unique case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB,
      OP_LOAD, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR: begin
        fl_d.zf = (acc_d == '0);
        fl_d.nf = acc_d[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      fl_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept && !mul_start;
      if (accept && !mul_start) begin
        acc  <= acc_d;
        fl_q <= fl_d;
      end else if (mul_last) begin
        acc     <= mul_lo;
        fl_q.cf <= |mul_hi;
        fl_q.vf <= |mul_hi;
        fl_q.zf <= (mul_lo == '0);
        fl_q.nf <= mul_lo[WIDTH-1];
      end
    end
  end

endmodule
